// File: rtl/clk_enable_gen_pkg.sv
// clk_enable_gen_pkg: shared constants and helpers for the clock-enable generator
package clk_enable_gen_pkg;
    typedef enum logic {
        MODE_PULSE = 1'b0,
        MODE_SQ    = 1'b1
    } mode_e;

    localparam int MAX_CH = 8;
    localparam int ADDR_W = 3;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr, input int num_ch);
        return int'(addr) < num_ch;
    endfunction
endpackage

// File: rtl/clk_enable_gen_ch.sv
// clk_enable_gen_ch: one divider channel with shadowed configuration applied at wrap
module clk_enable_gen_ch
    import clk_enable_gen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_phase,
    input  logic             i_mode,
    output logic             o_en,
    output logic             o_sq,
    output logic             o_pend,
    output logic             o_apply
);
    logic [DIV_W-1:0] r_div, r_cnt, r_sh_div, r_sh_phase;
    logic             r_mode, r_sh_mode, r_pend, r_en, r_sq;
    logic             w_on, w_last, w_apply;
    logic [DIV_W-1:0] w_half;

    assign w_on    = r_div != '0;
    assign w_last  = r_cnt == r_div - DIV_W'(1);
    assign w_apply = r_pend && (!w_on || w_last);
    assign w_half  = (r_div >> 1) + {{(DIV_W-1){1'b0}}, r_div[0]};

    // active set: swap in the shadow at the wrap (or at once when disabled), else count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= DIV_W'(DEFAULT_DIV);
            r_mode <= MODE_PULSE;
            r_cnt  <= '0;
        end else if (w_apply) begin
            r_div  <= r_sh_div;
            r_mode <= r_sh_mode;
            r_cnt  <= (r_sh_phase >= r_sh_div) ? '0 : r_sh_phase;
        end else begin
            r_cnt  <= (!w_on || w_last) ? '0 : r_cnt + DIV_W'(1);
        end
    end

    // shadow set: a write always wins, so a write coinciding with apply stays pending
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_div   <= '0;
            r_sh_phase <= '0;
            r_sh_mode  <= MODE_PULSE;
            r_pend     <= 1'b0;
        end else if (i_wr) begin
            r_sh_div   <= i_div;
            r_sh_phase <= i_phase;
            r_sh_mode  <= i_mode;
            r_pend     <= 1'b1;
        end else if (w_apply) begin
            r_pend     <= 1'b0;
        end
    end

    // registered outputs decoded from the current count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en <= 1'b0;
            r_sq <= 1'b0;
        end else begin
            r_en <= w_on && (r_cnt == '0);
            r_sq <= (r_mode == MODE_SQ) && w_on && (r_cnt < w_half);
        end
    end

    assign o_en    = r_en;
    assign o_sq    = r_sq;
    assign o_pend  = r_pend;
    assign o_apply = w_apply;
endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel clock-enable / square-wave generator with lock status
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_write,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] outclk_en,
    output logic [NUM_CH-1:0] outclk_sq,
    output logic              locked
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

    logic [NUM_CH-1:0] w_wr, w_pend, w_apply;
    logic              w_accept;
    logic [LW-1:0]     r_lock_cnt, w_lock_nxt;
    logic              r_locked;

    assign w_accept = cfg_write && addr_valid(cfg_addr, NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr[i] = w_accept && (cfg_addr == ADDR_W'(i));
        clk_enable_gen_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk   (refclk),
            .i_rst   (rst),
            .i_wr    (w_wr[i]),
            .i_div   (cfg_div),
            .i_phase (cfg_phase),
            .i_mode  (cfg_mode),
            .o_en    (outclk_en[i]),
            .o_sq    (outclk_sq[i]),
            .o_pend  (w_pend[i]),
            .o_apply (w_apply[i])
        );
    end

    assign w_lock_nxt = (w_accept || (|w_apply)) ? '0 :
                        (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + LW'(1);

    // lock counter; a saturating count implies no write or apply this cycle, so pending is unchanged
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_nxt;
            r_locked   <= (w_lock_nxt == LOCK_MAX) && !(|w_pend);
        end
    end

    assign locked = r_locked;
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: scoreboard bench for clk_enable_gen
module tb_clk_enable_gen;
    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int LK  = 16;

    typedef struct packed {
        logic [NCH-1:0] en;
        logic [NCH-1:0] sq;
        logic           lk;
    } obs_t;

    logic            refclk    = 1'b0;
    logic            rst       = 1'b1;
    logic            cfg_write = 1'b0;
    logic [2:0]      cfg_addr  = '0;
    logic [DW-1:0]   cfg_div   = '0;
    logic [DW-1:0]   cfg_phase = '0;
    logic            cfg_mode  = 1'b0;
    logic [NCH-1:0]  outclk_en, outclk_sq;
    logic            locked;

    int   n_pass  = 0;
    int   n_total = 0;
    obs_t exp_q[$];
    obs_t hist[$];
    int   m_div[NCH], m_cnt[NCH], m_mode[NCH], m_pend[NCH];
    int   s_div[NCH], s_ph[NCH], s_mode[NCH];
    bit   m_apply[NCH];
    int   m_lock;

    clk_enable_gen #(
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .DEFAULT_DIV (2),
        .LOCK_CYCLES (LK)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_write (cfg_write),
        .cfg_addr  (cfg_addr),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_mode  (cfg_mode),
        .outclk_en (outclk_en),
        .outclk_sq (outclk_sq),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    task automatic model_step();
        obs_t e = '0;
        bit acc = 1'b0;
        bit any_app = 1'b0;
        bit any_pend = 1'b0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = 2; m_mode[c] = 0; m_cnt[c] = 0; m_pend[c] = 0;
                s_div[c] = 0; s_ph[c] = 0; s_mode[c] = 0; m_apply[c] = 0;
            end
            m_lock = 0;
        end else begin
            acc = cfg_write && (int'(cfg_addr) < NCH);
            for (int c = 0; c < NCH; c++) begin
                e.en[c] = (m_div[c] > 0) && (m_cnt[c] == 0);
                e.sq[c] = (m_mode[c] == 1) && (2 * m_cnt[c] < m_div[c]);
                m_apply[c] = (m_pend[c] != 0) && (m_div[c] == 0 || m_cnt[c] == m_div[c] - 1);
                if (m_apply[c]) begin
                    any_app   = 1'b1;
                    m_cnt[c]  = (s_ph[c] < s_div[c]) ? s_ph[c] : 0;
                    m_div[c]  = s_div[c];
                    m_mode[c] = s_mode[c];
                    m_pend[c] = 0;
                end else begin
                    m_cnt[c] = (m_div[c] == 0) ? 0 : (m_cnt[c] + 1) % m_div[c];
                end
                if (acc && int'(cfg_addr) == c) begin
                    s_div[c] = int'(cfg_div); s_ph[c] = int'(cfg_phase); s_mode[c] = int'(cfg_mode);
                    m_pend[c] = 1;
                end
                any_pend |= (m_pend[c] != 0);
            end
            m_lock = (acc || any_app) ? 0 : ((m_lock < LK) ? m_lock + 1 : LK);
            e.lk = (m_lock == LK) && !any_pend;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r = 1'b0, input bit w = 1'b0, input int a = 0,
                       input int d = 0, input int p = 0, input bit m = 1'b0);
        obs_t o;
        rst = r; cfg_write = w; cfg_addr = 3'(a); cfg_div = DW'(d); cfg_phase = DW'(p); cfg_mode = m;
        model_step();
        @(posedge refclk);
        #1;
        o.en = outclk_en; o.sq = outclk_sq; o.lk = locked;
        hist.push_back(o);
        rst = 1'b0; cfg_write = 1'b0;
    endtask

    function automatic int next_en(input int ch, input int from);
        for (int i = (from < 0 ? 0 : from); i < hist.size(); i++)
            if (hist[i].en[ch]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        obs_t e;
        int first_en = -1;
        int first_lk = -1;
        int ones = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1);
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL reset_sb: got %b want %b", hist[$], e); else n_pass++;
        end
        for (int k = 1; k <= 20; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL idle_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
            if (first_en < 0 && hist[$].en == 3'b111) first_en = k;
            if (first_lk < 0 && hist[$].lk) first_lk = k;
            ones += int'(hist[$].en[0]);
        end
        n_total++;
        if (first_en !== 1) $display("FAIL first_pulse: got step %0d want 1", first_en); else n_pass++;
        n_total++;
        if (first_lk !== 16) $display("FAIL lock_after_reset: got step %0d want 16", first_lk); else n_pass++;
        n_total++;
        if (ones !== 10) $display("FAIL default_period: got %0d pulses want 10", ones); else n_pass++;
    endtask

    task automatic test_reconfig();
        obs_t e;
        int w, a = -1, l = -1, p0, p1;
        logic [4:0] sqp = '1;
        cyc(1'b0, 1'b1, 1, 5, 0, 1'b1);
        w = hist.size() - 1;
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL reconfig_sb write: got %b want %b", hist[$], e); else n_pass++;
        n_total++;
        if (hist[w].lk !== 1'b0) $display("FAIL lock_drop: got %b want 0", hist[w].lk); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL reconfig_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
            if (a < 0 && m_apply[1]) a = hist.size() - 1;
            if (a >= 0 && l < 0 && hist[$].lk) l = hist.size() - 1;
        end
        n_total++;
        if (a - w < 1 || a - w > 2) $display("FAIL reconfig_apply_delay: got %0d want 1..2", a - w); else n_pass++;
        p0 = next_en(1, a + 1);
        p1 = next_en(1, p0 + 1);
        n_total++;
        if (p0 !== a + 1 || p1 - p0 !== 5) $display("FAIL reconfig_period: got p0=%0d period=%0d want p0=%0d period=5", p0, p1 - p0, a + 1); else n_pass++;
        if (p0 >= 0) for (int i = 0; i < 5; i++) sqp[4-i] = hist[p0+i].sq[1];
        n_total++;
        if (sqp !== 5'b11100) $display("FAIL reconfig_sq_shape: got %b want 11100", sqp); else n_pass++;
        n_total++;
        if (l - a !== 16) $display("FAIL relock: got %0d want 16", l - a); else n_pass++;
    endtask

    task automatic test_disable();
        obs_t e;
        int w, p0, p1;
        logic z = 1'b0;
        cyc(1'b0, 1'b1, 0, 0, 0, 1'b0);
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL disable_sb write: got %b want %b", hist[$], e); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL disable_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
            if (k >= 4) z |= hist[$].en[0] | hist[$].sq[0];
        end
        n_total++;
        if (z !== 1'b0) $display("FAIL disabled_quiet: got %b want 0", z); else n_pass++;
        cyc(1'b0, 1'b1, 0, 3, 0, 1'b0);
        w = hist.size() - 1;
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL enable_sb write: got %b want %b", hist[$], e); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL enable_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
        end
        p0 = next_en(0, w + 1);
        p1 = next_en(0, p0 + 1);
        n_total++;
        if (p0 - w !== 2) $display("FAIL restart_delay: got %0d want 2", p0 - w); else n_pass++;
        n_total++;
        if (p1 - p0 !== 3) $display("FAIL restart_period: got %0d want 3", p1 - p0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t e;
        int w2, a = -1, c, p0, p1, p2;
        for (int k = 0; k < 4 && m_cnt[2] != 1; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL b2b_sb align: got %b want %b", hist[$], e); else n_pass++;
        end
        cyc(1'b0, 1'b1, 2, 4, 0, 1'b0);
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL b2b_sb write1: got %b want %b", hist[$], e); else n_pass++;
        cyc(1'b0, 1'b1, 2, 7, 0, 1'b0);
        w2 = hist.size() - 1;
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL b2b_sb write2: got %b want %b", hist[$], e); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL b2b_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
            if (a < 0 && m_apply[2]) a = hist.size() - 1;
        end
        p0 = next_en(2, a + 1);
        p1 = next_en(2, p0 + 1);
        n_total++;
        if (a - w2 !== 1 || p1 - p0 !== 7) $display("FAIL last_write_wins: got delay=%0d period=%0d want delay=1 period=7", a - w2, p1 - p0); else n_pass++;
        for (int k = 0; k < 10 && m_cnt[2] != 5; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL coincide_sb align: got %b want %b", hist[$], e); else n_pass++;
        end
        cyc(1'b0, 1'b1, 2, 4, 0, 1'b0);
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL coincide_sb write1: got %b want %b", hist[$], e); else n_pass++;
        cyc(1'b0, 1'b1, 2, 3, 0, 1'b0);
        c = hist.size() - 1;
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL coincide_sb write2: got %b want %b", hist[$], e); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL coincide_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
        end
        p0 = next_en(2, c + 1);
        p1 = next_en(2, p0 + 1);
        p2 = next_en(2, p1 + 1);
        n_total++;
        if (p0 !== c + 1 || p1 - p0 !== 4 || p2 - p1 !== 3)
            $display("FAIL coincide_periods: got start=%0d %0d,%0d want start=%0d 4,3", p0 - c, p1 - p0, p2 - p1, 1);
        else n_pass++;
    endtask

    task automatic test_bad_addr();
        obs_t e = '0;
        logic all_lk = 1'b1;
        for (int k = 0; k < 40 && !e.lk; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL badaddr_sb settle: got %b want %b", hist[$], e); else n_pass++;
        end
        n_total++;
        if (hist[$].lk !== 1'b1) $display("FAIL badaddr_prelock: got %b want 1", hist[$].lk); else n_pass++;
        cyc(1'b0, 1'b1, 5, 9, 0, 1'b1);
        all_lk &= hist[$].lk;
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL badaddr_sb write: got %b want %b", hist[$], e); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            cyc();
            all_lk &= hist[$].lk;
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL badaddr_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
        end
        n_total++;
        if (all_lk !== 1'b1) $display("FAIL badaddr_lock_kept: got %b want 1", all_lk); else n_pass++;
    endtask

    task automatic test_reset_discard();
        obs_t e;
        int ones = 0, a = -1, p0, p1;
        logic sq_seen = 1'b0;
        logic [3:0] sqp = '1;
        cyc(1'b0, 1'b1, 1, 4, 9, 1'b1);
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL discard_sb write: got %b want %b", hist[$], e); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1);
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL discard_sb reset: got %b want %b", hist[$], e); else n_pass++;
        end
        for (int k = 0; k < 12; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL discard_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
            ones += int'(hist[$].en[1]);
            sq_seen |= hist[$].sq[1];
        end
        n_total++;
        if (ones !== 6 || sq_seen !== 1'b0) $display("FAIL discard_defaults: got pulses=%0d sq=%b want pulses=6 sq=0", ones, sq_seen); else n_pass++;
        cyc(1'b0, 1'b1, 1, 4, 9, 1'b1);
        e = exp_q.pop_front(); n_total++;
        if (hist[$] !== e) $display("FAIL phase_sb write: got %b want %b", hist[$], e); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            cyc();
            e = exp_q.pop_front(); n_total++;
            if (hist[$] !== e) $display("FAIL phase_sb step %0d: got %b want %b", k, hist[$], e); else n_pass++;
            if (a < 0 && m_apply[1]) a = hist.size() - 1;
        end
        p0 = next_en(1, a + 1);
        p1 = next_en(1, p0 + 1);
        n_total++;
        if (p0 !== a + 1 || p1 - p0 !== 4) $display("FAIL phase_clamp: got start=%0d period=%0d want start=1 period=4", p0 - a, p1 - p0); else n_pass++;
        if (p0 >= 0) for (int i = 0; i < 4; i++) sqp[3-i] = hist[p0+i].sq[1];
        n_total++;
        if (sqp !== 4'b1100) $display("FAIL phase_sq_shape: got %b want 1100", sqp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reconfig();
        test_disable();
        test_back_to_back();
        test_bad_addr();
        test_reset_discard();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
